// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into addressed instruction words; `li` expansion under PSEUDO_LI_EN
module inst_encoder #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [6:0]  in_opcode,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_addr,
   output logic        err
);
`ifdef PSEUDO_LI_EN
   typedef enum logic [1:0] {EMPTY, FULL, PAIR} state_t;
`else
   typedef enum logic [1:0] {EMPTY, FULL} state_t;
`endif
   state_t state, state_nx, ld_st, drain_st;
   logic [31:0] w0, nxt_inst;
   logic ok, acc, take, ld, upd, shift, fits12;
   assign shift = in_opcode == 7'h13 && in_funct3[1:0] == 2'b01;
   assign fits12 = in_imm == {{20{in_imm[11]}}, in_imm[11:0]};
   assign in_ready = state == EMPTY || (state == FULL && out_ready);
   assign out_valid = state != EMPTY;
   assign acc = in_valid && in_ready;
   assign take = out_valid && out_ready;
   assign ld = acc && ok;
`ifdef PSEUDO_LI_EN
   logic [19:0] li_hi;
   logic [31:0] pend;
   logic two;
   // Upper part rounded so that the sign-extended low 12 bits add back to imm
   assign li_hi = in_imm[31:12] + {19'd0, in_imm[11]};
   assign two = in_fmt == 3'd6 && !fits12 && in_imm[11:0] != 12'd0;
   assign ld_st = two ? PAIR : FULL;
   assign drain_st = state == PAIR ? FULL : EMPTY;
   assign upd = ld || (take && state == PAIR);
   assign nxt_inst = ld ? w0 : pend;
   // Park the trailing addi of a split li until its lui has been taken
   always_ff @(posedge clk)
      if (ld) pend <= {in_imm[11:0], in_rd, 3'd0, in_rd, 7'h13};
`else
   assign ld_st = FULL;
   assign drain_st = EMPTY;
   assign upd = ld;
   assign nxt_inst = w0;
`endif
   // Encode the presented bundle and decide whether its immediate is in range
   always_comb begin
      ok = 1'b1;
      w0 = '0;
      case (in_fmt)
         3'd0: w0 = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         3'd1: begin
            w0 = {shift ? {in_funct7, in_imm[4:0]} : in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            ok = shift ? in_imm[31:5] == 27'd0 : fits12;
         end
         3'd2: begin
            w0 = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            ok = fits12;
         end
         3'd3: begin
            w0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode};
            ok = in_imm == {{19{in_imm[12]}}, in_imm[12:0]} && !in_imm[0];
         end
         3'd4: begin
            w0 = {in_imm[31:12], in_rd, in_opcode};
            ok = in_imm[11:0] == 12'd0;
         end
         3'd5: begin
            w0 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            ok = in_imm == {{11{in_imm[20]}}, in_imm[20:0]} && !in_imm[0];
         end
`ifdef PSEUDO_LI_EN
         3'd6: w0 = fits12 ? {in_imm[11:0], 5'd0, 3'd0, in_rd, 7'h13} : {li_hi, in_rd, 7'h37};
`endif
         default: ok = 1'b0;
      endcase
   end
   // Next state: a load wins, otherwise a taken word drains the register
   always_comb begin
      state_nx = state;
      if (ld) state_nx = ld_st;
      else if (take) state_nx = drain_st;
   end
   // State, output word, address counter and one-cycle reject pulse
   always_ff @(posedge clk)
      if (rst) begin
         state <= EMPTY;
         out_inst <= '0;
         out_addr <= RESET_PC;
         err <= 1'b0;
      end else begin
         state <= state_nx;
         err <= acc && !ok;
         if (take) out_addr <= out_addr + 32'd4;
         if (upd) out_inst <= nxt_inst;
      end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RV32I instruction encoder: accepts decoded instruction fields (format, opcode, funct, register addresses, 32-bit immediate) on a valid/ready input and emits packed 32-bit instruction words on a valid/ready output. Each word carries the instruction-memory byte address it belongs at. It is the producing end of the instruction path that the core's decoder consumes, and it feeds the instruction-memory loader and the self-check bench. Optionally expands the `li` pseudo-instruction into `lui`/`addi`.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, address assigned to the first emitted word after reset.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder accepts the bundle this cycle.
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=LI, 7=reserved.
- in_opcode  in  7  opcode field; ignored for LI.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field; used for R-type and for I-type shifts.
- in_rd, in_rs1, in_rs2  in  5 each  register addresses.
- in_imm  in  32  signed immediate as a byte value, not pre-shifted.
- out_valid  out  1  out_inst/out_addr valid.
- out_ready  in  1  consumer takes the word.
- out_inst  out  32  encoded instruction.
- out_addr  out  32  byte address of out_inst.
- err  out  1  one-cycle pulse: the accepted bundle was rejected.

## Operation
- Handshake: a transfer occurs when valid and ready are both high in the same cycle. Accepted bundles are always consumed, including rejected ones.
- Encoding, standard RV32I bit placement:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}. When opcode=7'h13 and funct3 is 001 or 101, the immediate field is {funct7, imm[4:0]}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Range checks; a failing bundle raises err and emits no word:
  - I/S: imm must equal sign-extension of imm[11:0].
  - Shift: imm[31:5] must be 0.
  - B: imm must equal sign-extension of imm[12:0], and imm[0] must be 0.
  - J: imm must equal sign-extension of imm[20:0], and imm[0] must be 0.
  - U: imm[11:0] must be 0.
  - fmt=7 is always rejected.
- FSM states:
  - EMPTY: output register holds no word. in_ready=1.
    - Accept of a valid single word → FULL.
    - Accept of a two-word LI → PAIR.
    - Accept of a rejected bundle → stay in EMPTY, err=1.
  - FULL: output register holds one word. in_ready=out_ready.
    - Output taken with no new accept → EMPTY.
    - Output taken and new bundle accepted in the same cycle → FULL or PAIR, loading the new word back-to-back.
  - PAIR: output register holds the `lui`; the `addi` is held internally. in_ready=0.
    - Output taken → load the `addi`, go to FULL.
- out_addr increments by 4 on every output transfer. Wrap-around from 32'hFFFF_FFFC to 0 is silent.

## Timing
- Reset values: out_valid=0, out_inst=0, out_addr=RESET_PC, err=0, state EMPTY; in_ready=1 one cycle after reset deasserts.
- Latency is 1 cycle: a word accepted in cycle N is presented with out_valid=1 in cycle N+1.
- Sustained throughput is 1 word/cycle with out_ready held high. LI costs 2 output cycles and stalls input for 1.
- While out_valid=1 and out_ready=0, out_inst and out_addr hold stable.
- err asserts in the cycle after the rejected accept, for exactly 1 cycle, and does not disturb a word already held in the output register.
- rst asserted in any state, including PAIR, discards held words and restores all reset values on the next edge.

## Configuration
- PSEUDO_LI_EN defined: fmt=6 is `li rd, imm`.
  - If imm fits in 12 bits signed: emit a single `addi rd, x0, imm`.
  - Otherwise: emit `lui rd, (imm+32'h800)>>12`.
  - Then, only if imm[11:0]≠0: emit `addi rd, rd, sext(imm[11:0])`.
- PSEUDO_LI_EN undefined: the PAIR state and expansion logic are absent; fmt=6 is rejected with err like fmt=7.

## Test plan
- I: fmt=1, opcode=7'h13, funct3=0, rd=1, rs1=0, imm=5 → out_inst=32'h0050_0093, out_addr=RESET_PC one cycle later.
- R: fmt=0, opcode=7'h33, funct7=7'h20, funct3=0, rd=3, rs1=1, rs2=2 → 32'h4020_81B3. Back-to-back with the I case, out_addr advances 0→4 with no bubble.
- LI (PSEUDO_LI_EN): rd=5, imm=32'h1234_5FFF → 32'h1234_62B7 then 32'hFFF2_8293, with in_ready=0 for one cycle. imm=32'h0000_1000 → single 32'h0000_12B7.
- Reject: fmt=3 (B), imm=3 (odd) → err one-cycle pulse, no out_valid, out_addr unchanged. Same check for fmt=5 (J), imm=32'h0010_0000 (out of range).
- Backpressure: out_ready=0 for 3 cycles with a word held → out_inst/out_addr stable and in_ready=0 throughout. Release → next bundle accepted in the same cycle.
- Reset in PAIR: assert rst while the `lui` is held → next cycle out_valid=0 and out_addr=RESET_PC. The pending `addi` is never emitted.
